sd_cmd_responder: RTL and testbench
===================================

# sd_cmd_responder

Card-side CMD-line engine for the SD command path. It deserialises host command frames from the CMD pin and checks their framing and CRC7. It hands index and argument to the card logic, then serialises a 48-bit or 136-bit response back onto the pin after a programmable Ncr gap. It replaces the fixed 49-bit parallel-to-serial card stub as the bench and card-model counterpart to `cmd_phys`/`cmd_controller`, and adds frame checking, response length selection and CRC generation.

## Interface
- `NCR_CYCLES`, default 2: idle cycles between response accept and response start bit; legal range 2..64.
- `CNT_WIDTH`, default 8: bit-counter width; must hold the value 136.
- `sd_clock`  in  1  sole clock; all sampling and driving happens on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable`  in  1  block active; low aborts any operation and forces IDLE.
- `cmd_in`  in  1  sampled CMD pin; idles high.
- `cmd_out`  out  1  bit driven onto CMD; reset value 1.
- `cmd_oe`  out  1  CMD drive enable; reset value 0.
- `cmd_valid`  out  1  one-cycle pulse, command received; reset value 0.
- `cmd_index`  out  6  received index; reset value 0; holds until the next `cmd_valid`.
- `cmd_arg`  out  32  received argument; reset value 0; holds until the next `cmd_valid`.
- `cmd_crc_err`  out  1  CRC7 mismatch, qualified by `cmd_valid`; reset value 0.
- `cmd_frame_err`  out  1  transmission bit ≠1 or end bit ≠1, qualified by `cmd_valid`; reset value 0.
- `resp_strobe`  in  1  request to send a response; sampled only in WAIT_RESP.
- `resp_long`  in  1  0 selects a 48-bit frame, 1 selects a 136-bit frame.
- `resp_index`  in  6  index field for short responses.
- `resp_payload`  in  120  long payload; short responses use bits [31:0].
- `resp_ack`  out  1  one-cycle pulse, response latched; reset value 0.
- `resp_done`  out  1  one-cycle pulse, end bit sent; reset value 0.
- `busy`  out  1  high in every state except IDLE; reset value 0.

## Operation
States are IDLE, RX, CHECK, WAIT_RESP, NCR, TX and DONE.

- **IDLE:** `cmd_oe`=0 and `cmd_out`=1. When `enable`=1 and `cmd_in`=0 (start bit), clear the counter and the CRC, shift in 0, and go to RX.
- **RX:** shift in 47 further bits, MSB first. Feed the CRC with frame bits 46..8, continuing from the start bit. After bit 0 (end bit) is sampled, go to CHECK.
- **CHECK:** lasts one cycle.
  - Pulse `cmd_valid` and load `cmd_index` and `cmd_arg`.
  - `cmd_crc_err` = (computed CRC ≠ frame[7:1]).
  - `cmd_frame_err` = (frame[46]≠1 or frame[0]≠1).
  - Go to WAIT_RESP, or to IDLE if either error flag is set.
- **WAIT_RESP:**
  - `resp_strobe`=1: latch `resp_long`, `resp_index` and `resp_payload`, pulse `resp_ack` the next cycle, and go to NCR.
  - `cmd_in`=0 while `resp_strobe`=0: the host has issued a new command. The pending response is dropped and the block goes straight to RX, counting this cycle as the start bit.
  - If both occur in the same cycle, `resp_strobe` wins.
- **NCR:** count `NCR_CYCLES` cycles with `cmd_oe`=0, then go to TX.
- **TX:** `cmd_oe`=1 and one bit per cycle, MSB first. `cmd_in` is ignored because it carries the block's own echo.
  - Short frame (48 bits): 0, 0, `resp_index`, payload[31:0], CRC7 over the first 40 bits, 1.
  - Long frame (136 bits): 0, 0, 6'b111111, payload[119:0], CRC7 over the payload only, 1.
- **DONE:** lasts one cycle. `cmd_oe`=0, `cmd_out`=1, `resp_done` pulses, then go to IDLE.

CRC7 rules:
- Polynomial x^7+x^3+1, initial value 0, computed serially one bit per cycle.

`enable` and reset behaviour:
- `enable` falling in any state: the next edge returns to IDLE with `cmd_oe`=0, and no `cmd_valid`, `resp_ack` or `resp_done` pulse is issued.
- `reset` asserted mid-operation: all outputs go to their reset values immediately, without waiting for an edge.

## Timing
- First TX bit is driven `NCR_CYCLES`+1 cycles after the `resp_strobe` sample edge.
- Frame boundaries:
  - Last RX sample → `cmd_valid`: 1 cycle.
  - `cmd_valid` → earliest `resp_strobe` accept: the next cycle.
  - `cmd_oe` high for exactly 48 or 136 consecutive cycles.
  - `resp_done` coincides with `cmd_oe` falling.
- Back-to-back: a start bit may be sampled on the cycle immediately after DONE.

## Configuration
- `SD_RESP_CRC7_EN` defined:
  - CRC7 is generated on responses.
  - CRC7 is checked on commands.
- `SD_RESP_CRC7_EN` undefined:
  - The response CRC field is 7'h7F.
  - `cmd_crc_err` is tied to 0.
  - No CRC logic is instantiated.

## Test plan
- **CMD41 receive:** host sends CMD41 (index 6'd41), argument 32'hFA74CD23, correct CRC → `cmd_valid` pulse, `cmd_index`=41, `cmd_arg`=FA74CD23, both error flags 0.
- **Short response:** `resp_strobe` with `resp_long`=0, `resp_index`=6'd63, payload[31:0]=32'h3BA692AF → `resp_ack`, 2 idle cycles, 48 bits matching the frame with correct CRC7 (7'h7F with the macro off), then `resp_done`.
- **Long response:** `resp_long`=1, payload=120'h0123…EF → 136-bit frame starting with 0,0,111111, `cmd_oe` high for exactly 136 cycles.
- **Bad frames:** command with one CRC bit flipped → `cmd_crc_err`=1, return to IDLE, no response accepted. End bit 0 → `cmd_frame_err`=1.
- **New command in WAIT_RESP:** a new start bit arrives before `resp_strobe` → second command received intact, no `resp_ack` for the first.
- **Reset and enable abort:** `reset` asserted at TX bit 20 → `cmd_oe`=0 and `cmd_out`=1 before the next edge, `busy`=0. `enable` dropped mid-RX → IDLE, no `cmd_valid`.

Source files
------------

// File: rtl/sd_cmd_responder_if.sv
// CMD-line and card-logic handshake bundle for sd_cmd_responder.
// slave = the responder, master = card logic / host model driving it.
interface sd_cmd_responder_if;
    logic         enable;
    logic         cmd_in;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         cmd_crc_err;
    logic         cmd_frame_err;
    logic         resp_strobe;
    logic         resp_long;
    logic [5:0]   resp_index;
    logic [119:0] resp_payload;
    logic         resp_ack;
    logic         resp_done;
    logic         busy;

    modport slave (
        input  enable, cmd_in, resp_strobe, resp_long, resp_index,
               resp_payload,
        output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg,
               cmd_crc_err, cmd_frame_err, resp_ack, resp_done, busy
    );

    modport master (
        output enable, cmd_in, resp_strobe, resp_long, resp_index,
               resp_payload,
        input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg,
               cmd_crc_err, cmd_frame_err, resp_ack, resp_done, busy
    );
endinterface

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD engine: receives 48-bit commands, sends 48/136-bit responses.
// Define SD_RESP_CRC7_EN to generate response CRC7 and check command CRC7.
module sd_cmd_responder #(
    parameter int NCR_CYCLES = 2,
    parameter int CNT_WIDTH  = 8
) (
    input logic               sd_clock,
    input logic               reset,
    sd_cmd_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RX, CHECK, WAIT_RESP, NCR, TX, DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RX_LAST  = CNT_WIDTH'(46);
    localparam logic [CNT_WIDTH-1:0] NCR_LAST = CNT_WIDTH'(NCR_CYCLES);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [45:0]          rx_q;
    logic [135:0]         tx_q;
    logic                 long_q;
    logic                 cmd_out_q, cmd_oe_q, cmd_valid_q;
    logic                 crc_err_q, frame_err_q;
    logic                 resp_ack_q, resp_done_q;
    logic [5:0]           index_q;
    logic [31:0]          arg_q;

    logic [CNT_WIDTH-1:0] emit_idx, tx_len, crc_pos;
    logic                 tx_shift, tx_bit, crc_out, crc_bad;

    // Bit being emitted: NCR's final edge drives bit 0, TX drives the rest.
    always_comb begin
        emit_idx = (state_q == NCR) ? '0 : cnt_q;
        tx_len   = long_q ? CNT_WIDTH'(136) : CNT_WIDTH'(48);
        crc_pos  = long_q ? CNT_WIDTH'(128) : CNT_WIDTH'(40);
        tx_shift = emit_idx < crc_pos;
        tx_bit   = tx_shift ? tx_q[135] : crc_out;
    end

`ifdef SD_RESP_CRC7_EN
    localparam logic [CNT_WIDTH-1:0] RX_CRC_LAST = CNT_WIDTH'(38);

    logic [6:0]           crc_q;
    logic [CNT_WIDTH-1:0] feed_lo;
    logic                 crc_in, crc_feed, tx_feed, tx_crc, tx_emit;

    always_comb begin
        feed_lo  = long_q ? CNT_WIDTH'(8) : '0;
        tx_emit  = (state_q == NCR && cnt_q == NCR_LAST) ||
                   (state_q == TX && cnt_q != tx_len);
        tx_feed  = tx_shift && emit_idx >= feed_lo;
        tx_crc   = !tx_shift && emit_idx < crc_pos + CNT_WIDTH'(7);
        crc_in   = bus.cmd_in;
        crc_feed = 1'b0;
        if (state_q == RX) begin
            crc_feed = cnt_q <= RX_CRC_LAST;
        end else if (tx_emit) begin
            crc_in   = tx_q[135];
            crc_feed = tx_feed;
        end
        crc_out  = tx_crc ? crc_q[6] : 1'b1;
        crc_bad  = crc_q != rx_q[6:0];
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else if (state_q == IDLE || state_q == WAIT_RESP) begin
            crc_q <= '0;
        end else if (crc_feed) begin
            crc_q <= {crc_q[5:0], 1'b0} ^
                     ((crc_q[6] ^ crc_in) ? 7'h09 : 7'h00);
        end else if (tx_emit && tx_crc) begin
            crc_q <= {crc_q[5:0], 1'b0};
        end
    end
`else
    assign crc_out = 1'b1;
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            long_q      <= 1'b0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            resp_ack_q  <= 1'b0;
            resp_done_q <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            resp_ack_q  <= 1'b0;
            resp_done_q <= 1'b0;
            if (!bus.enable) begin
                state_q   <= IDLE;
                cmd_oe_q  <= 1'b0;
                cmd_out_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!bus.cmd_in) begin
                            cnt_q   <= '0;
                            rx_q    <= '0;
                            state_q <= RX;
                        end
                    end
                    RX: begin
                        rx_q  <= {rx_q[44:0], bus.cmd_in};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == RX_LAST) begin
                            state_q     <= CHECK;
                            cmd_valid_q <= 1'b1;
                            index_q     <= rx_q[44:39];
                            arg_q       <= rx_q[38:7];
                            crc_err_q   <= crc_bad;
                            frame_err_q <= !rx_q[45] || !bus.cmd_in;
                        end
                    end
                    CHECK: begin
                        state_q <= (crc_err_q || frame_err_q) ? IDLE : WAIT_RESP;
                    end
                    WAIT_RESP: begin
                        if (bus.resp_strobe) begin
                            long_q     <= bus.resp_long;
                            tx_q       <= bus.resp_long
                                ? {2'b00, 6'h3F, bus.resp_payload, 8'h00}
                                : {2'b00, bus.resp_index,
                                   bus.resp_payload[31:0], 96'h0};
                            resp_ack_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= NCR;
                        end else if (!bus.cmd_in) begin
                            cnt_q   <= '0;
                            rx_q    <= '0;
                            state_q <= RX;
                        end
                    end
                    NCR: begin
                        if (cnt_q == NCR_LAST) begin
                            state_q   <= TX;
                            cnt_q     <= CNT_WIDTH'(1);
                            cmd_oe_q  <= 1'b1;
                            cmd_out_q <= tx_bit;
                            tx_q      <= {tx_q[134:0], 1'b0};
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    TX: begin
                        if (cnt_q == tx_len) begin
                            state_q     <= DONE;
                            cmd_oe_q    <= 1'b0;
                            cmd_out_q   <= 1'b1;
                            resp_done_q <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            cmd_out_q <= tx_bit;
                            if (tx_shift) tx_q <= {tx_q[134:0], 1'b0};
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_out       = cmd_out_q;
    assign bus.cmd_oe        = cmd_oe_q;
    assign bus.cmd_valid     = cmd_valid_q;
    assign bus.cmd_index     = index_q;
    assign bus.cmd_arg       = arg_q;
    assign bus.cmd_crc_err   = crc_err_q;
    assign bus.cmd_frame_err = frame_err_q;
    assign bus.resp_ack      = resp_ack_q;
    assign bus.resp_done     = resp_done_q;
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder (NCR_CYCLES = 2).
// Host frames are driven and response frames sampled on the falling edge.
module tb_sd_cmd_responder;
    logic clk;
    logic reset;
    int   nvec, nerr;
    int   nvalid, nack, ndone;
    int   v0, a0;

    logic [47:0]  f;
    logic [135:0] exp_f;
    logic [6:0]   cs;

    sd_cmd_responder_if bus ();

    sd_cmd_responder #(.NCR_CYCLES(2), .CNT_WIDTH(8)) dut (
        .sd_clock (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmd_valid) nvalid++;
        if (bus.resp_ack)  nack++;
        if (bus.resp_done) ndone++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [135:0] obs,
                       input logic [135:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ v[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx,
                                           input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7({96'h0, h}, 40), 1'b1};
    endfunction

    // Starts and ends on a falling edge; ends where cmd_valid should show.
    task automatic send_cmd(input logic [47:0] fr);
        for (int i = 47; i >= 0; i--) begin
            bus.cmd_in = fr[i];
            @(negedge clk);
        end
        bus.cmd_in = 1'b1;
    endtask

    task automatic do_resp(input string tag, input logic lng,
                           input logic [5:0] idx, input logic [119:0] pl,
                           input logic [135:0] expv, input int len);
        logic [135:0] got;
        int           oec;
        got = '0;
        oec = 0;
        bus.resp_long    = lng;
        bus.resp_index   = idx;
        bus.resp_payload = pl;
        bus.resp_strobe  = 1'b1;
        @(negedge clk);
        bus.resp_strobe = 1'b0;
        chk({tag, "_ack"}, bus.resp_ack, 1'b1);
        @(negedge clk);
        chk({tag, "_ncr1"}, bus.cmd_oe, 1'b0);
        @(negedge clk);
        chk({tag, "_ncr2"}, bus.cmd_oe, 1'b0);
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            got = {got[134:0], bus.cmd_out};
            if (bus.cmd_oe) oec++;
            @(negedge clk);
        end
        chk({tag, "_oe_cycles"}, 136'(oec), 136'(len));
        chk({tag, "_frame"}, got, expv);
        chk({tag, "_done"}, bus.resp_done, 1'b1);
        chk({tag, "_oe_fall"}, bus.cmd_oe, 1'b0);
        chk({tag, "_out_idle"}, bus.cmd_out, 1'b1);
        @(negedge clk);
        chk({tag, "_done_clr"}, bus.resp_done, 1'b0);
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        nvec = 0; nerr = 0; nvalid = 0; nack = 0; ndone = 0;
        reset            = 1'b1;
        bus.enable       = 1'b1;
        bus.cmd_in       = 1'b1;
        bus.resp_strobe  = 1'b0;
        bus.resp_long    = 1'b0;
        bus.resp_index   = '0;
        bus.resp_payload = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", bus.cmd_out, 1'b1);
        chk("rst_oe", bus.cmd_oe, 1'b0);
        chk("rst_valid", bus.cmd_valid, 1'b0);
        chk("rst_index", bus.cmd_index, 6'd0);
        chk("rst_arg", bus.cmd_arg, 32'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ack", bus.resp_ack, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // CMD41 receive then short response
        send_cmd(mk_cmd(6'd41, 32'hFA74CD23));
        chk("c41_valid", bus.cmd_valid, 1'b1);
        chk("c41_index", bus.cmd_index, 6'd41);
        chk("c41_arg", bus.cmd_arg, 32'hFA74CD23);
        chk("c41_crc_err", bus.cmd_crc_err, 1'b0);
        chk("c41_frame_err", bus.cmd_frame_err, 1'b0);
        @(negedge clk);
        chk("c41_valid_pulse", bus.cmd_valid, 1'b0);
        chk("c41_wait_busy", bus.busy, 1'b1);
`ifdef SD_RESP_CRC7_EN
        cs = crc7({96'h0, 2'b00, 6'd63, 32'h3BA692AF}, 40);
`else
        cs = 7'h7F;
`endif
        exp_f = {88'h0, 2'b00, 6'd63, 32'h3BA692AF, cs, 1'b1};
        do_resp("short", 1'b0, 6'd63,
                120'hDEAD_BEEF_0000_CAFE_0000_3BA6_92AF, exp_f, 48);
        chk("short_hold_index", bus.cmd_index, 6'd41);

        // back-to-back CMD0 (known CRC 0x4A) then long response
        send_cmd(48'h40_0000_0000_95);
        chk("c0_valid", bus.cmd_valid, 1'b1);
        chk("c0_index", bus.cmd_index, 6'd0);
        chk("c0_crc_err", bus.cmd_crc_err, 1'b0);
        @(negedge clk);
`ifdef SD_RESP_CRC7_EN
        cs = crc7({16'h0, 120'h0123_4567_89AB_CDEF_0123_4567_89AB_EF}, 120);
`else
        cs = 7'h7F;
`endif
        exp_f = {2'b00, 6'h3F, 120'h0123_4567_89AB_CDEF_0123_4567_89AB_EF,
                 cs, 1'b1};
        do_resp("long", 1'b1, 6'd5,
                120'h0123_4567_89AB_CDEF_0123_4567_89AB_EF, exp_f, 136);

        // CMD8 with a flipped CRC bit (good CRC 0x43)
        a0 = nack;
        send_cmd(48'h48_0000_01AA_85);
        chk("badcrc_valid", bus.cmd_valid, 1'b1);
        chk("badcrc_frame_err", bus.cmd_frame_err, 1'b0);
`ifdef SD_RESP_CRC7_EN
        chk("badcrc_crc_err", bus.cmd_crc_err, 1'b1);
        @(negedge clk);
        chk("badcrc_idle", bus.busy, 1'b0);
        bus.resp_strobe = 1'b1;
        repeat (3) @(negedge clk);
        bus.resp_strobe = 1'b0;
        @(negedge clk);
        chk("badcrc_no_ack", 136'(nack), 136'(a0));
        chk("badcrc_no_tx", bus.cmd_oe, 1'b0);
`else
        chk("badcrc_crc_err", bus.cmd_crc_err, 1'b0);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        chk("badcrc_abort_idle", bus.busy, 1'b0);
`endif

        // end bit 0
        f = mk_cmd(6'd17, 32'h0);
        f[0] = 1'b0;
        send_cmd(f);
        chk("endbit_frame_err", bus.cmd_frame_err, 1'b1);
        chk("endbit_crc_err", bus.cmd_crc_err, 1'b0);
        @(negedge clk);
        chk("endbit_idle", bus.busy, 1'b0);

        // new command while waiting for a response
        v0 = nvalid;
        a0 = nack;
        send_cmd(48'h48_0000_01AA_87);
        chk("c8_crc_err", bus.cmd_crc_err, 1'b0);
        chk("c8_arg", bus.cmd_arg, 32'h0000_01AA);
        @(negedge clk);
        send_cmd(mk_cmd(6'd17, 32'h0000_0200));
        chk("c17_valid", bus.cmd_valid, 1'b1);
        chk("c17_index", bus.cmd_index, 6'd17);
        chk("c17_arg", bus.cmd_arg, 32'h0000_0200);
        chk("c17_crc_err", bus.cmd_crc_err, 1'b0);
        @(negedge clk);
        chk("c17_two_valids", 136'(nvalid), 136'(v0 + 2));
        chk("c17_no_ack", 136'(nack), 136'(a0));

        // reset during TX bit 20
        bus.resp_long    = 1'b0;
        bus.resp_index   = 6'd17;
        bus.resp_payload = 120'h900;
        bus.resp_strobe  = 1'b1;
        @(negedge clk);
        bus.resp_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rsttx_oe_on", bus.cmd_oe, 1'b1);
        repeat (20) @(negedge clk);
        chk("rsttx_busy_pre", bus.busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rsttx_oe", bus.cmd_oe, 1'b0);
        chk("rsttx_out", bus.cmd_out, 1'b1);
        chk("rsttx_busy", bus.busy, 1'b0);
        chk("rsttx_index", bus.cmd_index, 6'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // enable dropped mid-RX
        v0 = nvalid;
        f = 48'h40_0000_0000_95;
        for (int i = 47; i >= 28; i--) begin
            bus.cmd_in = f[i];
            @(negedge clk);
        end
        chk("abort_busy_rx", bus.busy, 1'b1);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("abort_idle", bus.busy, 1'b0);
        bus.enable = 1'b1;
        bus.cmd_in = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_valid", 136'(nvalid), 136'(v0));
        chk("abort_still_idle", bus.busy, 1'b0);
        chk("total_done", 136'(ndone), 136'(2));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
